// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer: one outstanding imem request, valid/ready hand-off to decode,
// redirect on taken JAL/JALR/BRANCH with flush, and a sticky fault on misaligned targets.
module fetch_pc_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_instruction,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            takebranch,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  output logic            flush_out,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            discard_q, discard_d;
  logic            flush_q, flush_d;
  logic            mis_exc_q, mis_exc_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  // Redirect target decode
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, target;
  logic            is_ctrl, redirect;
  logic            unused_funct3;

  assign opcode = ex_instruction[6:0];
  assign imm_i  = {{(XLEN-12){ex_instruction[31]}}, ex_instruction[31:20]};
  assign imm_b  = {{(XLEN-13){ex_instruction[31]}}, ex_instruction[31], ex_instruction[7],
                   ex_instruction[30:25], ex_instruction[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){ex_instruction[31]}}, ex_instruction[31], ex_instruction[19:12],
                   ex_instruction[20], ex_instruction[30:21], 1'b0};
  assign unused_funct3 = ^ex_instruction[14:12];

  always_comb begin
    target  = '0;
    is_ctrl = 1'b1;
    unique case (opcode)
      OpJal:    target = ex_pc + imm_j;
      OpJalr:   target = (ex_rs1 + imm_i) & ~XLEN'(1);
      OpBranch: target = ex_pc + imm_b;
      default:  is_ctrl = 1'b0;
    endcase
  end

  assign redirect = ex_valid & takebranch & is_ctrl & (state_q != StFault);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      discard_q  <= 1'b0;
      flush_q    <= 1'b0;
      mis_exc_q  <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      discard_q  <= discard_d;
      flush_q    <= flush_d;
      mis_exc_q  <= mis_exc_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    discard_d  = discard_q;
    flush_d    = 1'b0;
    mis_exc_d  = 1'b0;
    mis_addr_d = mis_addr_q;
    if (redirect) begin
      flush_d    = 1'b1;
      if_valid_d = 1'b0;
      if (target[1:0] != 2'b00) begin
        mis_exc_d  = 1'b1;
        mis_addr_d = target;
        discard_d  = 1'b0;
        state_d    = StFault;
      end else begin
        pc_d = target;
        unique case (state_q)
          StWait: begin
            // A response arriving with the redirect is dropped; otherwise drop the next one.
            if (imem_rsp_valid) begin
              discard_d = 1'b0;
              state_d   = StReq;
            end else begin
              discard_d = 1'b1;
            end
          end
          StReq: begin
            if (imem_req_ready) begin
              discard_d = 1'b1;
              state_d   = StWait;
            end
          end
          default: state_d = StReq;
        endcase
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq:  if (imem_req_ready) state_d = StWait;
        StWait: begin
          if (imem_rsp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = StReq;
            end else begin
              if_instr_d = imem_rsp_data;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              state_d    = StHold;
            end
          end
        end
        StHold: begin
          if (if_ready) begin
            if_valid_d = 1'b0;
            pc_d       = pc_q + XLEN'(4);
            state_d    = StReq;
          end
        end
        StFault: if_valid_d = 1'b0;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state_q == StReq);
    imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
    if_valid       = if_valid_q;
    if_instr       = if_instr_q;
    if_pc          = if_pc_q;
    flush_out      = flush_q;
    misalign_exc   = mis_exc_q;
    misalign_addr  = mis_addr_q;
  end

endmodule
